node_inject_queue: RTL
======================

NODE_INJECT_QUEUE -- requirements
Module: node_inject_queue

Interface
REQ-001 SHALL have parameter HP, default 3: node X coordinate, 0..7.
REQ-002 SHALL have parameter VP, default 3: node Y coordinate, 0..7.
REQ-003 SHALL have parameter DEPTH, default 4: entries per QoS queue, power of 2, >=2.
REQ-004 SHALL have parameter STARVE_LIM, default 4: consecutive high-QoS grants tolerated while the low queue waits, >=1.
REQ-005 SHALL have parameter DATA_W, default 8: payload width.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports host_vld in 1 / host_rdy out 1: host-side handshake.
REQ-009 SHALL have ports host_type in 2 / host_qos in 1 / host_tgt in 6 / host_data in DATA_W: host packet fields.
REQ-010 SHALL have ports pg_en in 1 / pg_node in 6: fault enable and faulty node ID {y[2:0],x[2:0]}.
REQ-011 SHALL have ports pkt_in_vld out 1 / pkt_in_rdy in 1: A-port handshake to the node.
REQ-012 SHALL have ports pkt_in_type out 2 / pkt_in_qos out 1 / pkt_in_src out 6 / pkt_in_tgt out 6 / pkt_in_data out DATA_W: A-port fields.
REQ-013 SHALL have port drop_cnt  out  8  count of fault-dropped packets.

Function
REQ-014 SHALL keep two FIFOs, HI (host_qos=1) and LO (host_qos=0), each DEPTH entries; host_qos selects the FIFO.
REQ-015 SHALL drive host_rdy = !full(FIFO selected by host_qos); no write-through-read bypass when full.
REQ-016 SHALL write the selected FIFO on a rising edge with host_vld && host_rdy.
REQ-017 SHALL hold one output register; its state is EMPTY (pkt_in_vld=0) or HOLD (pkt_in_vld=1).
REQ-018 SHALL load the output register at an edge when state is EMPTY, or when state is HOLD with pkt_in_rdy=1, provided either FIFO is non-empty; otherwise HOLD+rdy -> EMPTY, and HOLD without rdy -> HOLD.
REQ-019 SHALL keep all pkt_in_* fields stable while pkt_in_vld=1 && pkt_in_rdy=0.
REQ-020 SHALL make pkt_in_vld high from edge k+1 when a packet is written at edge k into empty FIFOs and the output register is EMPTY.
REQ-021 SHALL sustain one packet per cycle when pkt_in_rdy is held at 1.
REQ-022 SHALL grant HI over LO, except that LO is granted when LO is non-empty and starve_cnt == STARVE_LIM.
REQ-023 SHALL increment starve_cnt on each HI grant while LO is non-empty, and clear it on a LO grant or whenever LO is empty.
REQ-024 SHALL drive pkt_in_src = {VP[2:0],HP[2:0]}; all other fields SHALL be passed from the queue entry unchanged.
REQ-025 SHALL preserve FIFO order within each QoS class.
REQ-026 SHALL increment drop_cnt by one per dropped packet, saturating at 255.

Reset
REQ-027 SHALL, with rst_n low, asynchronously clear both FIFOs, starve_cnt, and drop_cnt; output state SHALL be EMPTY and all pkt_in_* fields 0.
REQ-028 SHALL drive host_rdy=1 during reset, with no write occurring.
REQ-029 SHALL discard in-flight and queued packets when reset is asserted mid-operation; none is replayed after release.

Configuration
REQ-030 SHALL, with INJ_FAULT_DROP_EN defined, accept but not write a host packet with pg_en=1 && host_tgt==pg_node && host_type!=2'b11 (broadcast); the drop handshake uses host_rdy=1 regardless of fullness and increments drop_cnt.
REQ-031 SHALL, without INJ_FAULT_DROP_EN, queue every packet, ignore pg_en and pg_node, and tie drop_cnt to 0.

Verification
REQ-032 SHALL cover: one LO packet (tgt=6'h09, data=8'hA5) with rdy=1 -> pkt_in_vld one cycle after accept, src=6'h1B, tgt=6'h09, data=8'hA5.
REQ-033 SHALL cover: rdy=0, 5 HI writes with DEPTH=4 -> host_rdy low once HI holds 4 and the output register holds 1; output fields stable for 10 cycles.
REQ-034 SHALL cover: HI queue continuously full plus 1 LO packet, rdy=1, STARVE_LIM=4 -> LO packet is the 5th grant.
REQ-035 SHALL cover, with INJ_FAULT_DROP_EN defined: pg_en=1, pg_node=6'h12, host tgt=6'h12 type=2'b00 -> not emitted, drop_cnt=1; same with type=2'b11 -> emitted.
REQ-036 SHALL cover: rst_n pulsed low while pkt_in_vld=1 with 3 queued -> pkt_in_vld=0 immediately, no packet emitted after release.
REQ-037 SHALL cover: 300 drops -> drop_cnt=255.

Source files
------------

// File: rtl/node_inject_queue.sv
// Host-to-node injection queue: HI/LO QoS FIFOs, starvation-limited priority arbiter, one output register.
// Optional fault-drop filter enabled by defining INJ_FAULT_DROP_EN.
module node_inject_queue #(
  parameter int HP         = 3,
  parameter int VP         = 3,
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 4,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_vld,
  output logic              host_rdy,
  input  logic [1:0]        host_type,
  input  logic              host_qos,
  input  logic [5:0]        host_tgt,
  input  logic [DATA_W-1:0] host_data,
  input  logic              pg_en,
  input  logic [5:0]        pg_node,
  output logic              pkt_in_vld,
  input  logic              pkt_in_rdy,
  output logic [1:0]        pkt_in_type,
  output logic              pkt_in_qos,
  output logic [5:0]        pkt_in_src,
  output logic [5:0]        pkt_in_tgt,
  output logic [DATA_W-1:0] pkt_in_data,
  output logic [7:0]        drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = DATA_W + 8;
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [2:0] X_ID = 3'(HP);
  localparam logic [2:0] Y_ID = 3'(VP);
  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  logic [EW-1:0] host_entry;
  logic [EW-1:0] head [2];
  logic [1:0]    q_empty;
  logic [1:0]    q_full;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic          drop;

  logic          state_reg;
  logic [EW-1:0] out_reg;
  logic          qos_reg;
  logic [SW-1:0] starve_reg;

  logic          load;
  logic          sel_lo;
  logic          hi_ne;
  logic          lo_ne;

  assign host_entry = {host_type, host_tgt, host_data};

`ifdef INJ_FAULT_DROP_EN
  // Broadcasts are never dropped, even when addressed at the faulty node ID.
  assign drop = pg_en && (host_tgt == pg_node) && (host_type != 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 8'd0;
    end else if (host_vld && drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  logic unused_pg;
  assign unused_pg = ^{pg_en, pg_node};
  assign drop      = 1'b0;
  assign drop_cnt  = 8'd0;
`endif

  // A dropped packet is swallowed, so fullness must not stall it.
  assign host_rdy = drop ? 1'b1 : !q_full[host_qos];

  // Queue index 0 is LO, 1 is HI, matching the host_qos bit.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_q
      logic [EW-1:0] mem [DEPTH];
      logic [AW:0]   wr_ptr;
      logic [AW:0]   rd_ptr;

      assign push[gi]    = host_vld && host_rdy && !drop && (host_qos == gi[0]);
      assign q_empty[gi] = (wr_ptr == rd_ptr);
      assign q_full[gi]  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
      assign head[gi]    = mem[rd_ptr[AW-1:0]];

      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem[wr_ptr[AW-1:0]] <= host_entry;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end else begin
          if (push[gi]) wr_ptr <= wr_ptr + 1'b1;
          if (pop[gi])  rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  endgenerate

  assign hi_ne  = !q_empty[1];
  assign lo_ne  = !q_empty[0];
  assign load   = ((state_reg == ST_EMPTY) || pkt_in_rdy) && (hi_ne || lo_ne);
  assign sel_lo = lo_ne && (!hi_ne || (starve_reg == SW'(STARVE_LIM)));
  assign pop[0] = load && sel_lo;
  assign pop[1] = load && !sel_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_reg <= '0;
    end else if (!lo_ne || pop[0]) begin
      starve_reg <= '0;
    end else if (pop[1]) begin
      starve_reg <= starve_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      out_reg   <= '0;
      qos_reg   <= 1'b0;
    end else if (load) begin
      state_reg <= ST_HOLD;
      out_reg   <= sel_lo ? head[0] : head[1];
      qos_reg   <= !sel_lo;
    end else if ((state_reg == ST_HOLD) && pkt_in_rdy) begin
      state_reg <= ST_EMPTY;
    end
  end

  assign pkt_in_vld  = (state_reg == ST_HOLD);
  assign pkt_in_type = out_reg[EW-1 -: 2];
  assign pkt_in_tgt  = out_reg[DATA_W +: 6];
  assign pkt_in_data = out_reg[DATA_W-1:0];
  assign pkt_in_qos  = qos_reg;
  // Source fields are zeroed in reset along with the rest of the output register.
  assign pkt_in_src  = pkt_in_vld ? {Y_ID, X_ID} : 6'd0;

endmodule
